// File: rtl/prog_ram_arbiter_pkg.sv
// Shared encodings for the program RAM arbiter.
// Run states, read-return owner tags and the halt opcode.
package prog_ram_arbiter_pkg;

    localparam logic [1:0] ST_LOAD   = 2'b00;
    localparam logic [1:0] ST_RUN    = 2'b01;
    localparam logic [1:0] ST_HALTED = 2'b10;

    localparam logic [1:0] TAG_NONE = 2'b00;
    localparam logic [1:0] TAG_HOST = 2'b01;
    localparam logic [1:0] TAG_CPU  = 2'b10;

    localparam logic [15:0] HALT_WORD_DEF = 16'h3C00;
    localparam int          WAIT_W        = 4;

endpackage

// File: rtl/prog_ram_arbiter_if.sv
// Host load/debug port of the program RAM arbiter.
// The host drives requests; the arbiter returns grant and read data.
interface prog_ram_arbiter_if #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 16
);
    logic              host_req;
    logic              host_we;
    logic [ADDR_W-1:0] host_addr;
    logic [DATA_W-1:0] host_wdata;
    logic              host_gnt;
    logic              host_rvld;
    logic [DATA_W-1:0] host_rdata;

    modport master (
        output host_req, host_we, host_addr, host_wdata,
        input  host_gnt, host_rvld, host_rdata
    );

    modport slave (
        input  host_req, host_we, host_addr, host_wdata,
        output host_gnt, host_rvld, host_rdata
    );
endinterface

// File: rtl/prog_ram_grant.sv
// Single-grant arbitration of the program RAM between host and CPU.
// CPU has priority in RUN; a starved host is forced through after MAX_WAIT.
module prog_ram_grant
    import prog_ram_arbiter_pkg::*;
#(
    parameter int MAX_WAIT = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] state,
    input  logic       host_req,
    input  logic       cpu_read_en,
    output logic       host_gnt,
    output logic       cpu_gnt,
    output logic       cpu_stall
);
    logic [WAIT_W-1:0] wait_cnt;
    logic              starved;

    assign starved = (wait_cnt == WAIT_W'(MAX_WAIT));

    always_comb begin
        host_gnt = 1'b0;
        cpu_gnt  = 1'b0;
        case (state)
            ST_RUN: begin
                host_gnt = host_req && (!cpu_read_en || starved);
                cpu_gnt  = cpu_read_en && !host_gnt;
            end
            default: host_gnt = host_req;
        endcase
    end

    assign cpu_stall = cpu_read_en && !cpu_gnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wait_cnt <= '0;
        end else if (state == ST_RUN && host_req && !host_gnt) begin
            wait_cnt <= wait_cnt + 1'b1;
        end else begin
            wait_cnt <= '0;
        end
    end
endmodule

// File: rtl/prog_ram_arbiter.sv
// Program RAM owner: shares the RAM between fetch and host port and
// sequences the processor through LOAD, RUN and HALTED.
module prog_ram_arbiter
    import prog_ram_arbiter_pkg::*;
#(
    parameter int              ADDR_W    = 10,
    parameter int              DATA_W    = 16,
    parameter logic [DATA_W-1:0] HALT_WORD = HALT_WORD_DEF,
    parameter int              MAX_WAIT  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    prog_ram_arbiter_if.slave host,
    input  logic              host_go,
    input  logic              host_stop,
    input  logic              host_ack,
    output logic              cpu_start,
    input  logic              cpu_read_en,
    input  logic [ADDR_W-1:0] cpu_addr,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_data_vld,
    output logic              cpu_stall,
    output logic              ram_read_en,
    output logic              ram_write_en,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_din,
    input  logic [DATA_W-1:0] ram_dout,
    output logic              halted,
    output logic [1:0]        run_state
);
    logic [1:0]        state;
    logic [1:0]        state_nxt;
    logic [1:0]        tag_q;
    logic [1:0]        tag_nxt;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] host_hold;
    logic [DATA_W-1:0] cpu_hold;
    logic              host_gnt;
    logic              cpu_gnt;
    logic              host_vld;
    logic              halt_hit;

    prog_ram_grant #(
        .MAX_WAIT (MAX_WAIT)
    ) u_grant (
        .clk         (clk),
        .rst_n       (rst_n),
        .state       (state),
        .host_req    (host.host_req),
        .cpu_read_en (cpu_read_en),
        .host_gnt    (host_gnt),
        .cpu_gnt     (cpu_gnt),
        .cpu_stall   (cpu_stall)
    );

    assign host.host_gnt = host_gnt;

    assign ram_write_en = host_gnt && host.host_we;
    assign ram_read_en  = (host_gnt && !host.host_we) || cpu_gnt;
    assign ram_din      = ram_write_en ? host.host_wdata : '0;
    assign ram_addr     = host_gnt ? host.host_addr
                        : cpu_gnt  ? cpu_addr
                        : addr_q;

    assign host_vld        = (tag_q == TAG_HOST);
    assign cpu_data_vld    = (tag_q == TAG_CPU);
    assign host.host_rvld  = host_vld;
    assign host.host_rdata = host_vld ? ram_dout : host_hold;
    assign cpu_rdata       = cpu_data_vld ? ram_dout : cpu_hold;

    // Only a fetch returning while still in RUN may halt the core
    assign halt_hit = (state == ST_RUN) && cpu_data_vld
                   && (ram_dout == HALT_WORD);

    assign cpu_start = (state == ST_RUN);
    assign halted    = (state == ST_HALTED);
    assign run_state = state;

    always_comb begin
        state_nxt = state;
        case (state)
            ST_LOAD:   if (host_go) state_nxt = ST_RUN;
            ST_RUN: begin
                if (halt_hit)       state_nxt = ST_HALTED;
                else if (host_stop) state_nxt = ST_LOAD;
            end
            ST_HALTED: if (host_ack) state_nxt = ST_LOAD;
            default:   state_nxt = ST_LOAD;
        endcase
    end

    always_comb begin
        tag_nxt = TAG_NONE;
        if (host_gnt && !host.host_we) tag_nxt = TAG_HOST;
        else if (cpu_gnt)              tag_nxt = TAG_CPU;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_LOAD;
            tag_q     <= TAG_NONE;
            addr_q    <= '0;
            host_hold <= '0;
            cpu_hold  <= '0;
        end else begin
            state <= state_nxt;
            tag_q <= tag_nxt;
            if (host_gnt || cpu_gnt) addr_q <= ram_addr;
            if (host_vld) host_hold <= ram_dout;
            if (cpu_data_vld) cpu_hold <= ram_dout;
        end
    end
endmodule
